pc_sequencer: RTL and testbench

Fetch-side front end for KGP-RISC, directly upstream of instruction_fetcher.
- Owns the architectural PC and drives the word address into the synchronous instruction memory.
- Selects the next address from four sources: sequential, branch/jump redirect, stall hold, and halt/resume.
- Tags each memory output word with its PC and a valid bit, and counts issued instructions.
- Replaces the bare program_counter plus external pc+1 adder.

---
 rtl/kgp_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/next_pc_mux.sv | 60 ++++++
 rtl/pc_sequencer.sv | 63 ++++++
 tb/tb_pc_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/kgp_pkg.sv
// Shared types and defaults for the KGP-RISC fetch front end.
// Holds the sequencer state encoding and the reset address default.
package kgp_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam int          PC_W_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode side and the PC sequencer.
// The master drives stall/redirect/halt/resume; the slave owns the PC.
interface pc_sequencer_if #(
  parameter int PC_W = 32
);
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  logic            resume;
  logic [PC_W-1:0] fetch_addr;
  logic [PC_W-1:0] pc;
  logic            instr_valid;
  logic [PC_W-1:0] link_pc;
  logic [31:0]     issue_count;

  modport master (
    output stall, redirect, redirect_pc, halt, resume,
    input  fetch_addr, pc, instr_valid, link_pc, issue_count
  );

  modport slave (
    input  stall, redirect, redirect_pc, halt, resume,
    output fetch_addr, pc, instr_valid, link_pc, issue_count
  );
endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-address and next-state selection for pc_sequencer.
// RUN priority: stalled redirect holds, then redirect, then halt, then stall, then pc+1.
module next_pc_mux
  import kgp_pkg::*;
#(
  parameter int            PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  state_t          state,
  input  logic [PC_W-1:0] pc,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  input  logic            resume,
  input  logic            instr_valid,
  output logic [PC_W-1:0] fetch_addr,
  output state_t          next_state
);

  logic            redirect_q;
  logic            halt_q;
  logic [PC_W-1:0] pc_inc;

  // Redirect/halt belong to the presented instruction, so a bubble cannot raise them.
  assign redirect_q = redirect & instr_valid;
  assign halt_q     = halt & instr_valid;
  assign pc_inc     = pc + PC_W'(1);

  always_comb begin
    fetch_addr = pc;
    next_state = state;
    case (state)
      BOOT: begin
        fetch_addr = RESET_PC;
        next_state = RUN;
      end
      RUN: begin
        if (redirect_q && !stall) begin
          fetch_addr = redirect_pc;
        end else if (halt_q && !redirect_q) begin
          next_state = HALTED;
        end else if (!stall) begin
          fetch_addr = pc_inc;
        end
      end
      HALTED: begin
        if (resume) begin
          fetch_addr = pc_inc;
          next_state = RUN;
        end
      end
      default: begin
        fetch_addr = RESET_PC;
        next_state = BOOT;
      end
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner for KGP-RISC fetch: drives the instruction memory
// address, tags each returned word with its PC/valid and counts issued instructions.
module pc_sequencer
  import kgp_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input logic            clk,
  input logic            rst,
  pc_sequencer_if.slave  bus
);

  state_t          state_reg;
  state_t          state_next;
  logic [PC_W-1:0] pc_reg;
  logic            instr_valid_reg;
  logic [31:0]     issue_count_reg;
  logic [PC_W-1:0] fetch_addr;
  logic            count_en;

  next_pc_mux #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_next_pc_mux (
    .state       (state_reg),
    .pc          (pc_reg),
    .stall       (bus.stall),
    .redirect    (bus.redirect),
    .redirect_pc (bus.redirect_pc),
    .halt        (bus.halt),
    .resume      (bus.resume),
    .instr_valid (instr_valid_reg),
    .fetch_addr  (fetch_addr),
    .next_state  (state_next)
  );

  assign count_en = (state_reg == RUN) && instr_valid_reg && !bus.stall && !bus.halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      instr_valid_reg <= 1'b0;
      issue_count_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= fetch_addr;
      // Only RUN presents real instructions; entering HALTED inserts a bubble.
      instr_valid_reg <= (state_next == RUN);
      if (count_en) begin
        issue_count_reg <= issue_count_reg + 32'd1;
      end
    end
  end

  assign bus.fetch_addr  = fetch_addr;
  assign bus.pc          = pc_reg;
  assign bus.instr_valid = instr_valid_reg;
  assign bus.link_pc     = pc_reg + PC_W'(1);
  assign bus.issue_count = issue_count_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random control
// traffic, all compared against a behavioural model of the fetch rules.
module tb_pc_sequencer;

  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks      = 0;
  int n_miscompares = 0;

  // Behavioural model: where the machine is and what it has issued.
  bit          m_boot;
  bit          m_halted;
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_valid  = 1'b0;
    m_pc     = RESET_PC;
    m_count  = 32'd0;
  endtask

  // Set the control inputs for the coming edge; outputs settle 1 ns later.
  task automatic drive(input bit s, input bit r, input logic [31:0] rpc, input bit h, input bit res);
    bus.stall       = s;
    bus.redirect    = r;
    bus.redirect_pc = rpc;
    bus.halt        = h;
    bus.resume      = res;
    #1;
  endtask

  // Compare all outputs against the model, clock once, advance the model.
  task automatic cycle();
    logic [31:0] exp_fetch;
    bit          br_taken;
    bit          halt_taken;
    bit          accepted;
    br_taken   = 1'b0;
    halt_taken = 1'b0;
    accepted   = 1'b0;
    if (m_boot) begin
      exp_fetch = RESET_PC;
    end else if (m_halted) begin
      exp_fetch = bus.resume ? m_pc + 32'd1 : m_pc;
    end else begin
      br_taken   = m_valid && bus.redirect && !bus.stall;
      halt_taken = m_valid && bus.halt && !bus.redirect;
      if (br_taken)                     exp_fetch = bus.redirect_pc;
      else if (halt_taken || bus.stall) exp_fetch = m_pc;
      else                              exp_fetch = m_pc + 32'd1;
      accepted = m_valid && !bus.stall && !bus.halt;
    end
    check_value("fetch_addr", bus.fetch_addr, exp_fetch);
    check_value("pc", bus.pc, m_pc);
    check_value("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    check_value("link_pc", bus.link_pc, m_pc + 32'd1);
    check_value("issue_count", bus.issue_count, m_count);
    @(posedge clk);
    if (accepted) m_count = m_count + 32'd1;
    if (m_boot)         m_halted = 1'b0;
    else if (m_halted)  m_halted = !bus.resume;
    else                m_halted = halt_taken;
    m_boot  = 1'b0;
    m_valid = !m_halted;
    m_pc    = exp_fetch;
    @(negedge clk);
  endtask

  // Assert reset partway through a cycle and confirm it acts before any edge.
  task automatic mid_cycle_reset();
    #3;
    rst = 1'b1;
    #1;
    check_value("rst_pc", bus.pc, RESET_PC);
    check_value("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_value("rst_count", bus.issue_count, 32'd0);
    check_value("rst_fetch", bus.fetch_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
    bus.halt = 1'b0;  bus.resume = 1'b0;
    model_reset();
    #50;
    check_value("reset_pc", bus.pc, RESET_PC);
    check_value("reset_valid", 32'(bus.instr_valid), 32'd0);
    check_value("reset_count", bus.issue_count, 32'd0);
    #50;
    rst = 1'b0;   // t=100 is a falling edge

    // 1. free run
    for (int i = 0; i < 11; i++) begin
      drive(0, 0, 32'h0, 0, 0);
      cycle();
    end
    check_value("run_count10", bus.issue_count, 32'd10);
    check_value("run_pc10", bus.pc, 32'd10);

    // 2. stall at pc=5
    drive(0, 1, 32'd5, 0, 0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h0, 0, 0);
      check_value("stall_fetch", bus.fetch_addr, 32'd5);
      cycle();
      check_value("stall_pc", bus.pc, 32'd5);
      check_value("stall_valid", 32'(bus.instr_valid), 32'd1);
    end
    drive(0, 0, 32'h0, 0, 0); cycle();
    check_value("after_stall_pc", bus.pc, 32'd6);

    // 3. redirect at pc=7
    drive(0, 0, 32'h0, 0, 0); cycle();
    drive(0, 1, 32'h40, 0, 0);
    check_value("redir_fetch", bus.fetch_addr, 32'h40);
    check_value("redir_link", bus.link_pc, 32'd8);
    cycle();
    check_value("redir_pc", bus.pc, 32'h40);
    drive(0, 0, 32'h0, 0, 0); cycle();
    check_value("redir_pc_next", bus.pc, 32'h41);

    // 4. halt at pc=3, ignored controls, resume, then redirect+halt
    drive(0, 1, 32'd3, 0, 0); cycle();
    drive(0, 0, 32'h0, 1, 0); cycle();
    drive(1, 1, 32'h99, 0, 0);
    check_value("halted_fetch", bus.fetch_addr, 32'd3);
    check_value("halted_valid", 32'(bus.instr_valid), 32'd0);
    cycle();
    check_value("halted_pc", bus.pc, 32'd3);
    drive(0, 0, 32'h0, 0, 1);
    check_value("resume_fetch", bus.fetch_addr, 32'd4);
    cycle();
    check_value("resume_pc", bus.pc, 32'd4);
    check_value("resume_valid", 32'(bus.instr_valid), 32'd1);
    drive(0, 1, 32'h10, 1, 0); cycle();
    check_value("redir_halt_pc", bus.pc, 32'h10);
    check_value("redir_halt_valid", 32'(bus.instr_valid), 32'd1);
    drive(0, 0, 32'h0, 0, 0); cycle();
    check_value("redir_halt_next", bus.pc, 32'h11);

    // 5. wrap, then reset in the middle of a stall
    drive(0, 1, 32'hFFFF_FFFF, 0, 0); cycle();
    check_value("wrap_link", bus.link_pc, 32'h0);
    drive(0, 0, 32'h0, 0, 0); cycle();
    check_value("wrap_pc", bus.pc, 32'h0);
    drive(1, 0, 32'h0, 0, 0);
    mid_cycle_reset();

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1))) : $urandom;
      drive($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15, tgt,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 40);
      if (i == 200) begin
        mid_cycle_reset();
      end else begin
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miscompares);
    $finish;
  end

endmodule
